moore_seq_detector_nonoverlap: RTL and testbench

Single-bit serial sequence detector built as a Moore FSM. It detects the pattern 1101 on input `in`, with the MSB arriving first, and uses non-overlapping detection. Output `out` depends only on the current state. It pulses high for one clock after each complete detection. It sits on a serial bit stream as a framing/marker detector.

---
 rtl/moore_seq_detector_nonoverlap.sv | 67 ++++++
 tb/tb_moore_seq_detector_nonoverlap.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector_nonoverlap.sv
// ---------------------------------------------------------------------------
// moore_seq_detector_nonoverlap
//
// Purpose:
//   Serial detector for the bit pattern 1101. The first bit of the pattern
//   arrives first. It is built as a Moore FSM, so the detect flag depends
//   only on the registered state. Detection is non-overlapping: once a match
//   completes, none of its bits are reused, and the next bit starts a fresh
//   search.
//
// Ports:
//   clk    - rising-edge clock; every state update happens on this edge
//   arstn  - synchronous, active-high reset, sampled on the rising clk edge
//   in     - serial data bit, sampled on the rising clk edge
//   out    - detect flag, high for exactly one cycle after each 1101
// ---------------------------------------------------------------------------
module moore_seq_detector_nonoverlap (
    input  logic clk,
    input  logic arstn,
    input  logic in,
    output logic out
);

    // S0 idle, S1 "1", S2 "11", S3 "110", S4 "1101" matched.
    // The encodings 5..7 are unused and recover to S0.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register. Reset is synchronous, so it is sampled only on the
    // clock edge and overrides the data input.
    always_ff @(posedge clk) begin
        if (arstn) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // S4 acts like S0, so a completed match never seeds the next attempt.
    // Inside an attempt, only S2 keeps a partial match on a mismatch,
    // because "111" still ends in the valid prefix "11".
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = in ? S1 : S0;
            S1:      state_d = in ? S2 : S0;
            S2:      state_d = in ? S2 : S3;
            S3:      state_d = in ? S4 : S0;
            S4:      state_d = in ? S1 : S0;
            default: state_d = S0;
        endcase
    end

    // The output is decoded from the registered state only. There is no path
    // from in to out, and unused encodings can never raise the flag.
    assign out = (state_q == S4);

endmodule

// File: tb/tb_moore_seq_detector_nonoverlap.sv
// ---------------------------------------------------------------------------
// tb_moore_seq_detector_nonoverlap
//
// Purpose:
//   Directed testbench for moore_seq_detector_nonoverlap. Each stimulus bit
//   is applied together with the detect value worked out by hand for the
//   cycle after that edge. The expected value goes into a queue. An
//   independent monitor pops one entry per cycle and compares it with the
//   DUT output.
// ---------------------------------------------------------------------------
module tb_moore_seq_detector_nonoverlap;

    typedef struct {
        logic expOut;
        int   vecId;
    } expEntry_t;

    logic clk;
    logic arstn;
    logic in;
    logic out;

    expEntry_t expQ[$];
    int checksTotal;
    int checksPassed;
    int vecCount;

    moore_seq_detector_nonoverlap dut (
        .clk   (clk),
        .arstn (arstn),
        .in    (in),
        .out   (out)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one expected entry against the DUT output.
    task automatic checkOutput(input expEntry_t e);
        checksTotal++;
        if (out === e.expOut) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL vec%0d out: got %b expected %b", e.vecId, out, e.expOut);
        end
    endtask

    // Monitor. Runs on the falling edge, well away from the active edge, and
    // takes one expectation per cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    // Drives one cycle of inputs on the falling edge. After the rising edge,
    // it queues the value out should hold for the cycle that follows.
    task automatic applyStimulus(input logic rst, input logic bitIn, input logic expOut);
        expEntry_t e;
        @(negedge clk);
        arstn = rst;
        in    = bitIn;
        @(posedge clk);
        e.expOut = expOut;
        e.vecId  = vecCount;
        vecCount++;
        expQ.push_back(e);
    endtask

    // Applies len bits with reset low. Bits run MSB first, so bits[len-1]
    // goes first. exp gives the hand-computed out value after each edge.
    task automatic applySeq(input int len, input logic [15:0] bits, input logic [15:0] exp);
        for (int i = len - 1; i >= 0; i--) begin
            applyStimulus(1'b0, bits[i], exp[i]);
        end
    endtask

    initial begin
        int waitCycles;
        checksTotal  = 0;
        checksPassed = 0;
        vecCount     = 0;
        arstn        = 1'b1;
        in           = 1'b1;

        // Reset held for two edges with in=1: out stays low.
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);

        // Basic 1101: a single one-cycle pulse after bit 4.
        applySeq(4, 16'b1101, 16'b0001);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // 1101101: a single pulse. An overlapping detector would fire again
        // after bit 7.
        applySeq(7, 16'b1101101, 16'b0001000);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // 11011101: restart from S4 through S1/S2, so there are pulses after
        // bit 4 and bit 8.
        applySeq(8, 16'b11011101, 16'b00010001);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Back-to-back 11011101 again, plus 1101 1101 at the minimum spacing.
        applySeq(8, 16'b11011101, 16'b00010001);
        applySeq(4, 16'b1101, 16'b0001);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // 11101: the S2 self-loop gives a pulse after bit 5.
        applySeq(5, 16'b11101, 16'b00001);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // 101101: a pulse after bit 6 only.
        applySeq(6, 16'b101101, 16'b000001);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset in the middle of the prefix 110 clears it. The trailing
        // 1 then 101 completes a fresh 1101.
        applySeq(3, 16'b110, 16'b000);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applySeq(3, 16'b101, 16'b001);

        // Reset asserted while in S4: out drops at that edge.
        applyStimulus(1'b1, 1'b1, 1'b0);
        applySeq(4, 16'b1101, 16'b0001);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Let the monitor drain the queue, with a bounded wait.
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checksTotal++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
